// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous single-port RAM between the CPU
// and a DMA engine, with a starvation guard that forces DMA a slot.
module dmem_arbiter #(
  parameter int DBITS        = 32,
  parameter int ADDR_BITS    = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [DBITS-1:0]     cpu_addr,
  input  logic [DBITS-1:0]     cpu_wdata,
  output logic [DBITS-1:0]     cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [DBITS-1:0]     dma_addr,
  input  logic [DBITS-1:0]     dma_wdata,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  output logic [DBITS-1:0]     dma_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DBITS-1:0]     mem_wdata,
  input  logic [DBITS-1:0]     mem_rdata
);

  // A zero limit still needs a one-bit counter; it simply never leaves zero.
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_DMA_RD = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [SW-1:0]    starveCnt_q, starveCnt_d;
  logic [DBITS-1:0] cpuRdata_q;

  logic cpuMem, dmaMem, conflict;
  logic grantCpu, grantDma;
  logic unusedAddrBits;

  assign unusedAddrBits = ^{cpu_addr, dma_addr};

  // I/O space (top nibble 0xF) is decoded elsewhere and never touches memory.
  assign cpuMem   = cpu_req && (cpu_addr[DBITS-1 -: 4] != 4'hF);
  assign dmaMem   = dma_req && (dma_addr[DBITS-1 -: 4] != 4'hF);
  assign conflict = cpuMem && dmaMem;

  assign grantDma = reset && dmaMem && (!cpuMem || (starveCnt_q == LIMIT));
  assign grantCpu = reset && cpuMem && !grantDma;

  assign cpu_stall = reset && cpuMem && !grantCpu;
  assign dma_gnt   = grantDma;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grantCpu) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[ADDR_BITS+1:2];
      mem_wdata = cpu_wdata;
    end else if (grantDma) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr[ADDR_BITS+1:2];
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (grantCpu && !cpu_we) begin
      owner_d = OWN_CPU_RD;
    end else if (grantDma && !dma_we) begin
      owner_d = OWN_DMA_RD;
    end

    starveCnt_d = starveCnt_q;
    if (!dma_req || grantDma) begin
      starveCnt_d = '0;
    end else if (conflict && grantCpu && (starveCnt_q != LIMIT)) begin
      starveCnt_d = starveCnt_q + SW'(1);
    end
  end

  // Owner remembers whose read the RAM answers this cycle; CPU load data is
  // latched so it stays visible after the read-return cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN_IDLE;
      starveCnt_q <= '0;
      cpuRdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      starveCnt_q <= starveCnt_d;
      if (owner_q == OWN_CPU_RD) begin
        cpuRdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rdata  = (owner_q == OWN_CPU_RD) ? mem_rdata : cpuRdata_q;
  assign dma_rvalid = (owner_q == OWN_DMA_RD);
  assign dma_rdata  = (owner_q == OWN_DMA_RD) ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DBITS, default 32: data and CPU/DMA address width.
REQ-002 SHALL have parameter ADDR_BITS, default 11: data memory word-address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: consecutive CPU-won conflict cycles before DMA is forced a slot.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have ports cpu_req, cpu_we  input  1 each  CPU data access request and write qualifier.
REQ-007 SHALL have ports cpu_addr, cpu_wdata  input  DBITS each  CPU byte address and store data.
REQ-008 SHALL have ports cpu_rdata  output  DBITS  CPU load data; cpu_stall  output  1  CPU request not granted this cycle.
REQ-009 SHALL have ports dma_req, dma_we  input  1 each; dma_addr, dma_wdata  input  DBITS each  secondary requester.
REQ-010 SHALL have ports dma_gnt, dma_rvalid  output  1 each; dma_rdata  output  DBITS.
REQ-011 SHALL have ports mem_en, mem_we  output  1 each; mem_addr  output  ADDR_BITS; mem_wdata  output  DBITS; mem_rdata  input  DBITS (synchronous memory, 1-cycle read latency).

Function
REQ-012 SHALL treat a request as memory-bound only when addr[31:28] != 4'hF; I/O addresses (0xF0000000 and above) SHALL never be arbitrated, never drive mem_en, never stall.
REQ-013 SHALL drive mem_addr = granted addr[ADDR_BITS+1:2]; byte offset bits [1:0] ignored.
REQ-014 SHALL grant per cycle, combinationally from current inputs and registered state: CPU when only CPU requests; DMA when only DMA requests; on conflict CPU unless starve_cnt == STARVE_LIMIT, then DMA.
REQ-015 SHALL assert cpu_stall = cpu_req & memory-bound & not granted, same cycle.
REQ-016 SHALL assert dma_gnt same cycle as its DMA grant; DMA SHALL hold req/we/addr/wdata stable until dma_gnt; each dma_gnt consumes exactly one access.
REQ-017 SHALL drive mem_en=1 in any granted cycle, mem_we = granted we, mem_wdata = granted wdata; all mem outputs 0 when no grant.
REQ-018 SHALL keep a 2-bit registered owner state IDLE/CPU_RD/DMA_RD recording the read granted in the previous cycle; writes and no-grant cycles load IDLE.
REQ-019 SHALL in CPU_RD drive cpu_rdata = mem_rdata; otherwise cpu_rdata holds its last registered value (captured on CPU_RD cycles).
REQ-020 SHALL in DMA_RD assert dma_rvalid=1 and dma_rdata = mem_rdata for exactly one cycle; dma_rvalid=0 otherwise.
REQ-021 SHALL keep starve_cnt, width clog2(STARVE_LIMIT+1): increment (saturating at STARVE_LIMIT) on each conflict cycle CPU wins; clear on DMA grant or when dma_req=0.
REQ-022 SHALL allow back-to-back grants to alternate owners every cycle; read returns SHALL never collide because each cycle has at most one grant.
REQ-023 SHALL, with STARVE_LIMIT=0, grant DMA on every conflict.

Reset
REQ-024 SHALL, while reset=0, force owner=IDLE, starve_cnt=0, cpu_rdata=0, dma_rvalid=0, dma_rdata=0, independent of clk.
REQ-025 SHALL keep combinational outputs (dma_gnt, cpu_stall, mem_*) at 0 while reset=0; a read granted in the cycle reset asserts SHALL produce no dma_rvalid/cpu_rdata update.
REQ-026 SHALL resume arbitration on the first rising clk edge after reset returns to 1.

Verification
REQ-027 CPU read 0x00000040 alone -> mem_en=1, mem_addr=0x010, cpu_stall=0; next cycle cpu_rdata=mem_rdata.
REQ-028 CPU and DMA request continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, DMA 1 cycle (cpu_stall=1, dma_gnt=1), pattern repeats every 5 cycles.
REQ-029 DMA read 0x00000100, CPU idle -> dma_gnt same cycle, mem_addr=0x040; next cycle dma_rvalid=1 for one cycle with memory word.
REQ-030 CPU store to 0xF0000004 concurrent with DMA write -> DMA granted, cpu_stall=0, mem_we=1 with DMA data only.
REQ-031 Assert reset=0 asynchronously mid-DMA read grant -> dma_rvalid stays 0, starve_cnt=0; after release, DMA retry granted normally.
REQ-032 DMA alone, alternating read/write each cycle -> one access per cycle, dma_rvalid only after read cycles.
